// File: rtl/axi4lite_apb_bridge_pkg.sv
// Shared encodings for the AXI4-Lite to APB3 bridge: FSM states and response codes.
package axi_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [1:0] apb_resp(input logic slverr);
      return slverr ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi4lite_apb_bridge_if.sv
// Bus bundles for the bridge: AXI4-Lite (CPU side) and APB3 (peripheral side).
interface axi_lite_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic [AW-1:0] S_AWADDR;
   logic          S_AWVALID;
   logic          S_AWREADY;
   logic [DW-1:0] S_WDATA;
   logic          S_WVALID;
   logic          S_WREADY;
   logic [1:0]    S_BRESP;
   logic          S_BVALID;
   logic          S_BREADY;
   logic [AW-1:0] S_ARADDR;
   logic          S_ARVALID;
   logic          S_ARREADY;
   logic [DW-1:0] S_RDATA;
   logic [1:0]    S_RRESP;
   logic          S_RVALID;
   logic          S_RREADY;

   modport master (
      output S_AWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY,
             S_ARADDR, S_ARVALID, S_RREADY,
      input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
             S_ARREADY, S_RDATA, S_RRESP, S_RVALID
   );

   modport slave (
      input  S_AWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY,
             S_ARADDR, S_ARVALID, S_RREADY,
      output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
             S_ARREADY, S_RDATA, S_RRESP, S_RVALID
   );
endinterface

interface apb_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          M_PSEL;
   logic          M_PENABLE;
   logic [AW-1:0] M_PADDR;
   logic [DW-1:0] M_PWDATA;
   logic          M_PWRITE;
   logic [DW-1:0] M_PRDATA;
   logic          M_PREADY;
   logic          M_PSLVERR;

   modport master (
      output M_PSEL, M_PENABLE, M_PADDR, M_PWDATA, M_PWRITE,
      input  M_PRDATA, M_PREADY, M_PSLVERR
   );

   modport slave (
      input  M_PSEL, M_PENABLE, M_PADDR, M_PWDATA, M_PWRITE,
      output M_PRDATA, M_PREADY, M_PSLVERR
   );
endinterface

// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge, one transaction in flight, optional ACCESS timeout.
//
//   state     | meaning
//   ST_IDLE   | waiting for AW+W or AR; ready pulses combinationally for the chosen channel
//   ST_SETUP  | APB setup phase, PSEL=1 PENABLE=0
//   ST_ACCESS | APB access phase, waiting for PREADY or timeout
//   ST_RESP   | BVALID/RVALID held until the AXI master accepts
module axi4lite_apb_bridge
   import axi_apb_pkg::*;
#(
   parameter int AW  = 16,
   parameter int DW  = 16,
   parameter int TMO = 0
) (
   input  logic      CLK,
   input  logic      RESETN,
   axi_lite_if.slave s_axi,
   apb_if.master     m_apb
);

   localparam int             CW       = (TMO > 0) ? $clog2(TMO + 1) : 1;
   localparam logic [CW-1:0]  TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

   state_t        state_q;
   logic          last_wr_q;
   logic          psel_q;
   logic          penable_q;
   logic          pwrite_q;
   logic          bvalid_q;
   logic          rvalid_q;
   logic [1:0]    resp_q;
   logic [AW-1:0] paddr_q;
   logic [DW-1:0] pwdata_q;
   logic [DW-1:0] rdata_q;
   logic [CW-1:0] cnt_q;

   logic wr_cand;
   logic rd_cand;
   logic pick_wr;
   logic pick_rd;
   logic in_idle;
   logic tmo_hit;
   logic resp_done;

   // On a tie the channel not served last time wins; last_wr resets to 1 so reads go first.
   assign wr_cand   = s_axi.S_AWVALID & s_axi.S_WVALID;
   assign rd_cand   = s_axi.S_ARVALID;
   assign pick_wr   = wr_cand & (~rd_cand | ~last_wr_q);
   assign pick_rd   = rd_cand & (~wr_cand |  last_wr_q);
   assign in_idle   = (state_q == ST_IDLE) & RESETN;
   assign tmo_hit   = (TMO > 0) && (cnt_q == TMO_LAST);
   assign resp_done = (bvalid_q & s_axi.S_BREADY) | (rvalid_q & s_axi.S_RREADY);

   assign s_axi.S_AWREADY = in_idle & pick_wr;
   assign s_axi.S_WREADY  = in_idle & pick_wr;
   assign s_axi.S_ARREADY = in_idle & pick_rd;
   assign s_axi.S_BVALID  = bvalid_q;
   assign s_axi.S_BRESP   = resp_q;
   assign s_axi.S_RVALID  = rvalid_q;
   assign s_axi.S_RRESP   = resp_q;
   assign s_axi.S_RDATA   = rdata_q;

   assign m_apb.M_PSEL    = psel_q;
   assign m_apb.M_PENABLE = penable_q;
   assign m_apb.M_PADDR   = paddr_q;
   assign m_apb.M_PWDATA  = pwdata_q;
   assign m_apb.M_PWRITE  = pwrite_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= ST_IDLE;
         last_wr_q <= 1'b1;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         resp_q    <= RESP_OKAY;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_wr || pick_rd) begin
                  paddr_q   <= pick_wr ? s_axi.S_AWADDR : s_axi.S_ARADDR;
                  if (pick_wr) pwdata_q <= s_axi.S_WDATA;
                  pwrite_q  <= pick_wr;
                  last_wr_q <= pick_wr;
                  psel_q    <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (m_apb.M_PREADY) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  resp_q    <= apb_resp(m_apb.M_PSLVERR);
                  if (!pwrite_q) rdata_q <= m_apb.M_PRDATA;
                  bvalid_q  <= pwrite_q;
                  rvalid_q  <= ~pwrite_q;
                  state_q   <= ST_RESP;
               end else if (tmo_hit) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  resp_q    <= RESP_SLVERR;
                  if (!pwrite_q) rdata_q <= '0;
                  bvalid_q  <= pwrite_q;
                  rvalid_q  <= ~pwrite_q;
                  state_q   <= ST_RESP;
               end else if (cnt_q != TMO_LAST) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_done) begin
                  bvalid_q <= 1'b0;
                  rvalid_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4lite_apb_bridge.sv
// Directed bench for axi4lite_apb_bridge: latency, wait states, errors, arbitration, timeout, reset.
module tb_axi4lite_apb_bridge;

   logic CLK;
   logic RESETN;
   int   checks;
   int   errors;

   axi_lite_if #(.AW(16), .DW(16)) axi ();
   apb_if      #(.AW(16), .DW(16)) apb ();

   axi4lite_apb_bridge #(.AW(16), .DW(16), .TMO(16)) dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .s_axi  (axi.slave),
      .m_apb  (apb.master)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_resp(input string tag);
      int n;
      n = 0;
      while (!(axi.S_BVALID || axi.S_RVALID) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      assert (axi.S_BVALID || axi.S_RVALID) else begin
         errors++;
         $error("FAIL %s response_valid observed=0 expected=1", tag);
      end
   endtask

   task automatic ack();
      axi.S_BREADY = 1'b1;
      axi.S_RREADY = 1'b1;
      tick();
      axi.S_BREADY = 1'b0;
      axi.S_RREADY = 1'b0;
   endtask

   task automatic do_reset();
      RESETN = 1'b0;
      tick();
      tick();
      RESETN = 1'b1;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RESETN = 1'b0;
      axi.S_AWADDR = '0; axi.S_AWVALID = 1'b0; axi.S_WDATA = '0; axi.S_WVALID = 1'b0;
      axi.S_BREADY = 1'b0; axi.S_ARADDR = '0; axi.S_ARVALID = 1'b0; axi.S_RREADY = 1'b0;
      apb.M_PRDATA = '0; apb.M_PREADY = 1'b0; apb.M_PSLVERR = 1'b0;

      // reset state, including a pending AR that must not be acknowledged
      tick();
      axi.S_ARVALID = 1'b1;
      #1;
      chk1("rst_psel", apb.M_PSEL, 1'b0);
      chk1("rst_penable", apb.M_PENABLE, 1'b0);
      chk1("rst_bvalid", axi.S_BVALID, 1'b0);
      chk1("rst_rvalid", axi.S_RVALID, 1'b0);
      chk1("rst_arready", axi.S_ARREADY, 1'b0);
      chk16("rst_paddr", apb.M_PADDR, 16'h0000);
      axi.S_ARVALID = 1'b0;
      tick();
      RESETN = 1'b1;
      tick();

      // zero-wait write
      axi.S_AWADDR = 16'h0010; axi.S_AWVALID = 1'b1;
      axi.S_WDATA  = 16'hBEEF; axi.S_WVALID  = 1'b1;
      apb.M_PREADY = 1'b1;
      #1;
      chk1("w0_awready", axi.S_AWREADY, 1'b1);
      chk1("w0_wready", axi.S_WREADY, 1'b1);
      chk1("w0_arready", axi.S_ARREADY, 1'b0);
      tick();
      axi.S_AWVALID = 1'b0; axi.S_WVALID = 1'b0;
      chk1("w0_setup_psel", apb.M_PSEL, 1'b1);
      chk1("w0_setup_penable", apb.M_PENABLE, 1'b0);
      chk16("w0_paddr", apb.M_PADDR, 16'h0010);
      chk16("w0_pwdata", apb.M_PWDATA, 16'hBEEF);
      chk1("w0_pwrite", apb.M_PWRITE, 1'b1);
      tick();
      chk1("w0_access_psel", apb.M_PSEL, 1'b1);
      chk1("w0_access_penable", apb.M_PENABLE, 1'b1);
      chk1("w0_access_bvalid", axi.S_BVALID, 1'b0);
      tick();
      chk1("w0_bvalid_t3", axi.S_BVALID, 1'b1);
      chk2("w0_bresp", axi.S_BRESP, 2'b00);
      chk1("w0_psel_drop", apb.M_PSEL, 1'b0);
      chk16("w0_paddr_hold", apb.M_PADDR, 16'h0010);
      ack();
      chk1("w0_bvalid_clr", axi.S_BVALID, 1'b0);

      // read with 3 wait states, RREADY withheld for 5 cycles
      apb.M_PREADY = 1'b0;
      axi.S_ARADDR = 16'h0024; axi.S_ARVALID = 1'b1;
      #1;
      chk1("r3_arready", axi.S_ARREADY, 1'b1);
      tick();
      axi.S_ARVALID = 1'b0;
      chk1("r3_setup_psel", apb.M_PSEL, 1'b1);
      chk1("r3_pwrite", apb.M_PWRITE, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("r3_wait_psel", apb.M_PSEL, 1'b1);
         chk1("r3_wait_penable", apb.M_PENABLE, 1'b1);
         chk16("r3_wait_paddr", apb.M_PADDR, 16'h0024);
      end
      tick();
      apb.M_PREADY = 1'b1; apb.M_PRDATA = 16'h1234;
      chk1("r3_4th_psel", apb.M_PSEL, 1'b1);
      tick();
      apb.M_PREADY = 1'b0; apb.M_PRDATA = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         chk1("r3_rvalid_hold", axi.S_RVALID, 1'b1);
         chk16("r3_rdata", axi.S_RDATA, 16'h1234);
         chk2("r3_rresp", axi.S_RRESP, 2'b00);
         tick();
      end
      ack();
      chk1("r3_rvalid_clr", axi.S_RVALID, 1'b0);

      // slave errors
      apb.M_PREADY = 1'b1; apb.M_PSLVERR = 1'b1;
      axi.S_AWADDR = 16'h0030; axi.S_AWVALID = 1'b1;
      axi.S_WDATA  = 16'h5555; axi.S_WVALID  = 1'b1;
      tick();
      axi.S_AWVALID = 1'b0; axi.S_WVALID = 1'b0;
      wait_resp("werr");
      chk1("werr_bvalid", axi.S_BVALID, 1'b1);
      chk2("werr_bresp", axi.S_BRESP, 2'b10);
      ack();
      apb.M_PRDATA = 16'hA5A5;
      axi.S_ARADDR = 16'h0032; axi.S_ARVALID = 1'b1;
      tick();
      axi.S_ARVALID = 1'b0;
      wait_resp("rerr");
      chk1("rerr_rvalid", axi.S_RVALID, 1'b1);
      chk2("rerr_rresp", axi.S_RRESP, 2'b10);
      chk16("rerr_rdata", axi.S_RDATA, 16'hA5A5);
      ack();
      apb.M_PSLVERR = 1'b0;

      // arbitration: read first after reset, then alternating
      do_reset();
      apb.M_PREADY = 1'b1; apb.M_PRDATA = 16'h1111;
      axi.S_AWVALID = 1'b1; axi.S_WVALID = 1'b0;
      #1;
      chk1("arb_aw_only_awready", axi.S_AWREADY, 1'b0);
      chk1("arb_aw_only_wready", axi.S_WREADY, 1'b0);
      axi.S_AWVALID = 1'b0; axi.S_WVALID = 1'b1;
      #1;
      chk1("arb_w_only_awready", axi.S_AWREADY, 1'b0);
      chk1("arb_w_only_wready", axi.S_WREADY, 1'b0);
      axi.S_AWADDR = 16'h0100; axi.S_AWVALID = 1'b1;
      axi.S_WDATA  = 16'h0F0F; axi.S_WVALID  = 1'b1;
      axi.S_ARADDR = 16'h0200; axi.S_ARVALID = 1'b1;
      #1;
      chk1("arb1_arready", axi.S_ARREADY, 1'b1);
      chk1("arb1_awready", axi.S_AWREADY, 1'b0);
      tick();
      axi.S_ARVALID = 1'b0;
      chk1("arb1_setup_awready", axi.S_AWREADY, 1'b0);
      chk1("arb1_pwrite", apb.M_PWRITE, 1'b0);
      wait_resp("arb1");
      chk1("arb1_rvalid", axi.S_RVALID, 1'b1);
      chk16("arb1_rdata", axi.S_RDATA, 16'h1111);
      chk1("arb1_resp_awready", axi.S_AWREADY, 1'b0);
      ack();
      axi.S_ARVALID = 1'b1;
      #1;
      chk1("arb2_awready", axi.S_AWREADY, 1'b1);
      chk1("arb2_arready", axi.S_ARREADY, 1'b0);
      tick();
      axi.S_AWVALID = 1'b0; axi.S_WVALID = 1'b0;
      chk1("arb2_pwrite", apb.M_PWRITE, 1'b1);
      chk16("arb2_paddr", apb.M_PADDR, 16'h0100);
      wait_resp("arb2");
      chk1("arb2_bvalid", axi.S_BVALID, 1'b1);
      ack();
      axi.S_AWVALID = 1'b1; axi.S_WVALID = 1'b1;
      #1;
      chk1("arb3_arready", axi.S_ARREADY, 1'b1);
      chk1("arb3_awready", axi.S_AWREADY, 1'b0);
      tick();
      axi.S_ARVALID = 1'b0;
      wait_resp("arb3");
      ack();
      #1;
      chk1("arb4_awready", axi.S_AWREADY, 1'b1);
      tick();
      axi.S_AWVALID = 1'b0; axi.S_WVALID = 1'b0;
      wait_resp("arb4");
      ack();

      // ACCESS timeout after 16 cycles, then a normal read
      apb.M_PREADY = 1'b0; apb.M_PRDATA = 16'hFFFF;
      axi.S_ARADDR = 16'h0040; axi.S_ARVALID = 1'b1;
      tick();
      axi.S_ARVALID = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk1("tmo_psel_held", apb.M_PSEL, 1'b1);
         if (i < 15) tick();
      end
      tick();
      chk1("tmo_psel_drop", apb.M_PSEL, 1'b0);
      chk1("tmo_rvalid", axi.S_RVALID, 1'b1);
      chk2("tmo_rresp", axi.S_RRESP, 2'b10);
      chk16("tmo_rdata", axi.S_RDATA, 16'h0000);
      ack();
      apb.M_PREADY = 1'b1; apb.M_PRDATA = 16'h0777;
      axi.S_ARVALID = 1'b1;
      tick();
      axi.S_ARVALID = 1'b0;
      wait_resp("post_tmo");
      chk2("post_tmo_rresp", axi.S_RRESP, 2'b00);
      chk16("post_tmo_rdata", axi.S_RDATA, 16'h0777);
      ack();

      // reset during a write ACCESS
      apb.M_PREADY = 1'b0;
      axi.S_AWADDR = 16'h0050; axi.S_AWVALID = 1'b1;
      axi.S_WDATA  = 16'h1357; axi.S_WVALID  = 1'b1;
      tick();
      axi.S_AWVALID = 1'b0; axi.S_WVALID = 1'b0;
      tick();
      chk1("mid_access_penable", apb.M_PENABLE, 1'b1);
      #2;
      RESETN = 1'b0;
      #1;
      chk1("mid_rst_psel", apb.M_PSEL, 1'b0);
      chk1("mid_rst_penable", apb.M_PENABLE, 1'b0);
      chk1("mid_rst_bvalid", axi.S_BVALID, 1'b0);
      tick();
      tick();
      RESETN = 1'b1;
      tick();
      chk1("post_rst_bvalid", axi.S_BVALID, 1'b0);
      apb.M_PREADY = 1'b1; apb.M_PRDATA = 16'h2468;
      axi.S_ARADDR = 16'h0060; axi.S_ARVALID = 1'b1;
      #1;
      chk1("post_rst_arready", axi.S_ARREADY, 1'b1);
      tick();
      axi.S_ARVALID = 1'b0;
      chk16("post_rst_paddr", apb.M_PADDR, 16'h0060);
      wait_resp("post_rst");
      chk1("post_rst_rvalid", axi.S_RVALID, 1'b1);
      chk16("post_rst_rdata", axi.S_RDATA, 16'h2468);
      chk2("post_rst_rresp", axi.S_RRESP, 2'b00);
      ack();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
